intr_controller: RTL

- Parametrised interrupt controller between external interrupt lines (today the CPU's raw 8-bit `interrupcion` bus) and the single-cycle CPU.
- Captures requests as edges or levels, applies a writable mask and fixed priority, and raises a single request to the CPU.
- Runs a request/acknowledge/end-of-interrupt handshake and supplies the serviced source's ID and vector address.

---
 rtl/intr_controller_if.sv | 23 ++
 rtl/intr_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/intr_controller_if.sv
// CPU-side handshake of the interrupt controller: request/ack/eoi plus the
// ID and vector address of the source being requested or serviced.
interface intr_controller_if #(
    parameter int unsigned ID_W   = 3,
    parameter int unsigned ADDR_W = 10
);
    logic              irq_req;
    logic              irq_ack;
    logic [ID_W-1:0]   irq_id;
    logic [ADDR_W-1:0] vec_addr;
    logic              irq_eoi;
    logic              in_service;

    modport master (
        output irq_req, irq_id, vec_addr, in_service,
        input  irq_ack, irq_eoi
    );

    modport slave (
        input  irq_req, irq_id, vec_addr, in_service,
        output irq_ack, irq_eoi
    );
endinterface

// File: rtl/intr_controller.sv
// Interrupt controller: edge or level capture, writable mask, fixed
// lowest-index priority and a req/ack/eoi handshake towards the CPU.
module intr_controller #(
    parameter int unsigned       N_IRQ      = 8,
    parameter int unsigned       ID_W       = 3,
    parameter int unsigned       ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3F0,
    parameter int unsigned       VEC_STRIDE = 2,
    parameter bit                EDGE_MODE  = 1'b1,
    parameter logic [N_IRQ-1:0]  MASK_RST   = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_in,
    output logic [N_IRQ-1:0]  mask_out,
    output logic [N_IRQ-1:0]  pending,
    intr_controller_if.master cpu
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_next;
    logic [N_IRQ-1:0] mask_r;
    logic [ID_W-1:0]  id_r, id_next;
    logic             req_r, req_next;
    logic             svc_r, svc_next;
    logic             take_ack;
    logic [N_IRQ-1:0] eligible;
    logic             prio_hit;
    logic [ID_W-1:0]  prio_idx;

    if (EDGE_MODE) begin : g_edge
        logic [N_IRQ-1:0] hist;
        logic [N_IRQ-1:0] pend_r;
        logic [N_IRQ-1:0] clr;

        assign clr = take_ack ? (N_IRQ'(1) << id_r) : '0;

        // A fresh rising edge is OR-ed in after the ack clear, so it wins.
        always_ff @(posedge clk) begin
            if (!reset) begin
                hist   <= irq_in;
                pend_r <= '0;
            end else begin
                hist   <= irq_in;
                pend_r <= (pend_r & ~clr) | (irq_in & ~hist);
            end
        end
        assign pending = pend_r;
    end else begin : g_level
        assign pending = irq_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_r <= MASK_RST;
        end else if (mask_we) begin
            mask_r <= mask_in;
        end
    end

    assign eligible = pending & mask_r;

    always_comb begin
        prio_hit = 1'b0;
        prio_idx = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (eligible[i] && !prio_hit) begin
                prio_hit = 1'b1;
                prio_idx = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            id_r  <= '0;
            req_r <= 1'b0;
            svc_r <= 1'b0;
        end else begin
            state <= state_next;
            id_r  <= id_next;
            req_r <= req_next;
            svc_r <= svc_next;
        end
    end

    always_comb begin
        state_next = state;
        id_next    = id_r;
        req_next   = req_r;
        svc_next   = svc_r;
        take_ack   = 1'b0;
        unique case (state)
            IDLE: begin
                if (prio_hit) begin
                    id_next    = prio_idx;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (cpu.irq_ack) begin
                    take_ack   = 1'b1;
                    req_next   = 1'b0;
                    svc_next   = 1'b1;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (cpu.irq_eoi) begin
                    svc_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mask_out       = mask_r;
    assign cpu.irq_req    = req_r;
    assign cpu.in_service = svc_r;
    assign cpu.irq_id     = id_r;
    assign cpu.vec_addr   = ADDR_W'(32'(VEC_BASE) + 32'(id_r) * VEC_STRIDE);
endmodule
